// File: rtl/ntt_out_streamer.sv
// Collects NTT result coefficients written in any order and streams them out in index order 0..N-1.
// Optional NTT_OUT_PINGPONG_EN adds a second bank so filling and streaming can overlap.
module ntt_out_streamer #(
  parameter int N  = 128,
  parameter int DW = 14,
  parameter int OW = 16,
  localparam int AW = $clog2(N)
) (
  input  logic          clk3,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          done,
  input  logic          hold,
  output logic          out_valid,
  output logic [OW-1:0] out_data,
  output logic          busy,
  output logic          err_ovf
);

  typedef enum logic [1:0] {S_FILL, S_ARM, S_STREAM} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          out_valid_q, out_valid_d;
  logic [OW-1:0] out_data_q, out_data_d;
  logic          busy_q, busy_d;
  logic          err_ovf_q, err_ovf_d;
  logic          mem_we;
  logic [DW-1:0] rd_data;

`ifdef NTT_OUT_PINGPONG_EN
  logic          fill_bank_q, fill_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic          pend_q, pend_d;
  logic [DW-1:0] mem_q [2][N];

  always_ff @(posedge clk3) begin
    if (mem_we) mem_q[fill_bank_q][wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_bank_q][idx_q];

  always_ff @(posedge clk3 or negedge rst_n) begin
    if (!rst_n) begin
      fill_bank_q <= 1'b0;
      rd_bank_q   <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      fill_bank_q <= fill_bank_d;
      rd_bank_q   <= rd_bank_d;
      pend_q      <= pend_d;
    end
  end
`else
  logic [DW-1:0] mem_q [N];

  always_ff @(posedge clk3) begin
    if (mem_we) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[idx_q];
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    err_ovf_d   = 1'b0;
    mem_we      = 1'b0;
`ifdef NTT_OUT_PINGPONG_EN
    fill_bank_d = fill_bank_q;
    rd_bank_d   = rd_bank_q;
    pend_d      = pend_q;
    mem_we      = wr_en;
    // A done while a bank is armed or streaming is parked; a second one has nowhere to go.
    if (done && state_q != S_FILL) begin
      if (pend_q) err_ovf_d = 1'b1;
      else        pend_d    = 1'b1;
    end
    unique case (state_q)
      S_FILL: begin
        if (done) begin
          rd_bank_d   = fill_bank_q;
          fill_bank_d = ~fill_bank_q;
          state_d     = S_ARM;
        end
      end
      S_ARM: begin
        if (!hold) begin
          state_d = S_STREAM;
          idx_d   = '0;
        end
      end
      S_STREAM: begin
        out_valid_d = 1'b1;
        out_data_d  = OW'(rd_data);
        idx_d       = idx_q + AW'(1);
        if (idx_q == AW'(N - 1)) begin
          if (pend_q || done) begin
            rd_bank_d   = fill_bank_q;
            fill_bank_d = ~fill_bank_q;
            pend_d      = 1'b0;
            state_d     = S_ARM;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
`else
    mem_we    = wr_en && !busy_q;
    err_ovf_d = busy_q && (wr_en || done);
    unique case (state_q)
      S_FILL: begin
        if (done && !busy_q) state_d = S_ARM;
      end
      S_ARM: begin
        if (!hold) begin
          state_d = S_STREAM;
          idx_d   = '0;
        end
      end
      S_STREAM: begin
        out_valid_d = 1'b1;
        out_data_d  = OW'(rd_data);
        idx_d       = idx_q + AW'(1);
        if (idx_q == AW'(N - 1)) state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
`endif
    // Covers the last-beat cycle so busy drops together with out_valid.
    busy_d = (state_d != S_FILL) || out_valid_d;
  end

  always_ff @(posedge clk3 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_ntt_out_streamer.sv
// Scoreboard bench for ntt_out_streamer (single-bank build).
module tb_ntt_out_streamer;
  localparam int N  = 128;
  localparam int DW = 14;
  localparam int OW = 16;
  localparam int AW = 7;

  logic          clk3 = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          done = 1'b0;
  logic          hold = 1'b0;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          busy;
  logic          err_ovf;

  int            checks = 0;
  int            errors = 0;
  logic [OW-1:0] exp_q[$];
  logic [DW-1:0] mem_m [N];
  int            beats_seen = 0;
  int            run_len = 0;

  ntt_out_streamer #(.N(N), .DW(DW), .OW(OW)) dut (
    .clk3      (clk3),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .done      (done),
    .hold      (hold),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .err_ovf   (err_ovf)
  );

  always #5 clk3 = ~clk3;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every beat, checks idle zeroing and run length.
  initial begin
    forever begin
      @(negedge clk3);
      if (!rst_n) begin
        run_len = 0;
      end else if (out_valid) begin
        beats_seen++;
        run_len++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0d required=no_beat", out_data);
        end else begin
          check("beat_data", int'(out_data), int'(exp_q.pop_front()));
        end
      end else begin
        check("idle_data_zero", int'(out_data), 0);
        if (run_len != 0) begin
          check("run_length", run_len, N);
          check("busy_fall", int'(busy), 0);
          run_len = 0;
        end
      end
    end
  end

  function automatic int bitrev(input int k);
    int r = 0;
    for (int i = 0; i < AW; i++) if (k[i]) r |= 1 << (AW - 1 - i);
    return r;
  endfunction

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = DW'(d);
    mem_m[a] = DW'(d);
    @(negedge clk3);
    wr_en = 1'b0;
  endtask

  task automatic push_block();
    for (int i = 0; i < N; i++) exp_q.push_back(OW'(mem_m[i]));
  endtask

  task automatic start_block(input bit with_wr, input int a, input int d, output int lat);
    if (with_wr) begin
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = DW'(d);
      mem_m[a] = DW'(d);
    end
    push_block();
    done = 1'b1;
    @(negedge clk3);
    done  = 1'b0;
    wr_en = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk3);
      lat++;
    end
  endtask

  task automatic wait_end();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk3);
      n++;
    end
    check("stream_end_busy", int'(busy), 0);
    check("stream_end_valid", int'(out_valid), 0);
  endtask

  initial begin
    int lat;
    int seen;
    int errs;
    int n;
    int target;

    repeat (3) @(negedge clk3);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err_ovf", int'(err_ovf), 0);
    rst_n = 1'b1;
    @(negedge clk3);

    // Basic order: bit-reversed writes of k*96
    for (int k = 0; k < N; k++) wr(bitrev(k), k * 96);
    check("err_idle", int'(err_ovf), 0);
    start_block(1'b0, 0, 0, lat);
    check("latency_basic", lat, 2);
    wait_end();

    // Write to 127 in the same cycle as done
    for (int k = 0; k < N - 1; k++) wr(k, 12288 - k * 5);
    start_block(1'b1, 127, 12288, lat);
    check("latency_simul", lat, 2);
    check("simul_last_value", int'(mem_m[127]), 12288);
    wait_end();

    // Hold gating, then hold toggling mid-stream
    hold = 1'b1;
    push_block();
    done = 1'b1;
    @(negedge clk3);
    done = 1'b0;
    seen = 0;
    repeat (10) begin
      if (out_valid) seen++;
      @(negedge clk3);
    end
    check("hold_blocks_start", seen, 0);
    check("busy_while_held", int'(busy), 1);
    hold = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk3);
      lat++;
    end
    check("latency_hold", lat, 2);
    repeat (20) begin
      @(negedge clk3);
      hold = ~hold;
    end
    hold = 1'b0;
    wait_end();

    // Overflow while streaming: writes and done are dropped
    start_block(1'b0, 0, 0, lat);
    check("latency_ovf", lat, 2);
    repeat (10) @(negedge clk3);
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = DW'(77);
    @(negedge clk3);
    wr_en = 1'b0;
    check("ovf_wr_pulse", int'(err_ovf), 1);
    done = 1'b1;
    @(negedge clk3);
    done = 1'b0;
    check("ovf_done_pulse", int'(err_ovf), 1);
    @(negedge clk3);
    check("ovf_clear", int'(err_ovf), 0);
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = DW'(77); done = 1'b1;
    @(negedge clk3);
    wr_en = 1'b0; done = 1'b0;
    check("ovf_both_pulse", int'(err_ovf), 1);
    @(negedge clk3);
    check("ovf_single_pulse", int'(err_ovf), 0);
    wait_end();
    start_block(1'b0, 0, 0, lat);
    check("latency_after_ovf", lat, 2);
    wait_end();

    // Reset at beat 40
    target = beats_seen + 40;
    start_block(1'b0, 0, 0, lat);
    n = 0;
    while (beats_seen < target && n < 200) begin
      @(negedge clk3);
      n++;
    end
    check("reached_beat_40", beats_seen, target);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(out_valid), 0);
    check("async_rst_data", int'(out_data), 0);
    check("async_rst_busy", int'(busy), 0);
    exp_q.delete();
    repeat (3) @(negedge clk3);
    #2 rst_n = 1'b1;
    @(negedge clk3);
    seen = 0;
    repeat (20) begin
      if (out_valid) seen++;
      @(negedge clk3);
    end
    check("no_resume_after_rst", seen, 0);
    start_block(1'b0, 0, 0, lat);
    check("latency_after_rst", lat, 2);
    wait_end();

    // Idle protocol with random writes and hold, no done
    seen = 0;
    errs = 0;
    repeat (1000) begin
      hold    = 1'($urandom_range(0, 1));
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, N - 1));
      wr_data = DW'($urandom_range(0, 12288));
      if (wr_en) mem_m[wr_addr] = wr_data;
      @(negedge clk3);
      if (out_valid || out_data != '0) seen++;
      if (err_ovf) errs++;
    end
    wr_en = 1'b0;
    hold  = 1'b0;
    check("idle_protocol", seen, 0);
    check("idle_no_err", errs, 0);
    start_block(1'b0, 0, 0, lat);
    check("latency_random", lat, 2);
    wait_end();

    repeat (5) @(negedge clk3);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
